// File: rtl/ripple_count_sequencer_pkg.sv
// Shared definitions for the ripple counter sequencer: FSM state encoding and sampling limits.
package ripple_count_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_RUN    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_HOLD   = 3'd5
  } seq_state_t;

  localparam int RETRY_LIMIT = 4;
  localparam int TRY_W       = 2;
  // SAMPLE spends this many cycles flushing the synchroniser before the first pair compare.
  localparam int SMP_FLUSH   = 2;

endpackage

// File: rtl/ripple_sample_sync.sv
// N-bit 2-flop synchroniser for the asynchronous counter outputs, plus a third stage for pair comparison.
// One new synchronised sample per cycle; stable is high when the last two synchronised samples agree.
module ripple_sample_sync #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic         stable
);

  logic [N-1:0] s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign q      = s2_q;
  assign stable = (s2_q == s3_q);

endmodule

// File: rtl/ripple_count_sequencer.sv
// Sequences an external ripple counter: clear, gate TARGET pulses, settle, sample, then hand off via valid/ready.
// Latency 1+CLR_CYC+target+SET_CYC+3 cycles; result is held with valid high until result_ready.
module ripple_count_sequencer
  import ripple_count_sequencer_pkg::*;
#(
  parameter int N       = 4,
  parameter int CLR_CYC = 2,
  parameter int SET_CYC = 3
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  input  logic         stop,
  input  logic [N-1:0] target,
  input  logic [N-1:0] cnt_in,
  output logic         cnt_clear,
  output logic         cnt_en,
  output logic [N-1:0] result,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         mismatch,
  output logic         busy
);

  seq_state_t       state_q, state_d;
  logic [3:0]       cyc_q, cyc_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic [N:0]       issued_q, issued_d;
  logic [N-1:0]     tgt_q, tgt_d;
  logic [N-1:0]     res_d;
  logic             mm_d, vld_d;
  logic [N-1:0]     smp;
  logic             smp_stable;

  ripple_sample_sync #(.N(N)) u_sync (
    .clk    (clk),
    .clear  (clear),
    .d      (cnt_in),
    .q      (smp),
    .stable (smp_stable)
  );

  // issued counts pulses as they are scheduled, so it always equals the cnt_en cycles already driven.
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    try_d    = try_q;
    issued_d = issued_q;
    tgt_d    = tgt_q;
    res_d    = result;
    mm_d     = mismatch;
    vld_d    = result_valid;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_CLR;
          tgt_d    = target;
          issued_d = '0;
          cyc_d    = '0;
          try_d    = '0;
        end
      end
      ST_CLR: begin
        if (cyc_q == 4'(CLR_CYC - 1)) begin
          cyc_d = '0;
          if (tgt_q == '0) begin
            state_d = ST_SETTLE;
          end else begin
            state_d  = ST_RUN;
            issued_d = (N+1)'(1);
          end
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      ST_RUN: begin
        if (stop || (issued_q == {1'b0, tgt_q})) begin
          state_d = ST_SETTLE;
          cyc_d   = '0;
        end else begin
          issued_d = issued_q + (N+1)'(1);
        end
      end
      ST_SETTLE: begin
        if (cyc_q == 4'(SET_CYC - 1)) begin
          state_d = ST_SAMPLE;
          cyc_d   = '0;
          try_d   = '0;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (cyc_q != 4'(SMP_FLUSH)) begin
          cyc_d = cyc_q + 4'd1;
        end else if (smp_stable) begin
          state_d = ST_HOLD;
          res_d   = smp;
          mm_d    = (smp != issued_q[N-1:0]);
          vld_d   = 1'b1;
        end else if (try_q == TRY_W'(RETRY_LIMIT - 1)) begin
          state_d = ST_HOLD;
          res_d   = smp;
          mm_d    = 1'b1;
          vld_d   = 1'b1;
        end else begin
          try_d = try_q + TRY_W'(1);
        end
      end
      ST_HOLD: begin
        if (result_ready) begin
          state_d = ST_IDLE;
          vld_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      cyc_q        <= '0;
      try_q        <= '0;
      issued_q     <= '0;
      tgt_q        <= '0;
      result       <= '0;
      mismatch     <= 1'b0;
      result_valid <= 1'b0;
      cnt_clear    <= 1'b0;
      cnt_en       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      try_q        <= try_d;
      issued_q     <= issued_d;
      tgt_q        <= tgt_d;
      result       <= res_d;
      mismatch     <= mm_d;
      result_valid <= vld_d;
      cnt_clear    <= (state_d == ST_CLR);
      cnt_en       <= (state_d == ST_RUN);
      busy         <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_ripple_count_sequencer.sv
// Bench for ripple_count_sequencer: ideal ripple counter model with 2-cycle output delay and a result scoreboard.
module tb_ripple_count_sequencer;

  localparam int N       = 4;
  localparam int CLR_CYC = 2;
  localparam int SET_CYC = 3;

  logic         clk;
  logic         clear;
  logic         start;
  logic         stop;
  logic [N-1:0] target;
  logic [N-1:0] cnt_in;
  logic         cnt_clear;
  logic         cnt_en;
  logic [N-1:0] result;
  logic         result_valid;
  logic         result_ready;
  logic         mismatch;
  logic         busy;

  typedef struct {
    logic [N-1:0] res;
    logic         mm;
    bit           chk_res;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ripple_count_sequencer #(.N(N), .CLR_CYC(CLR_CYC), .SET_CYC(SET_CYC)) dut (
    .clk          (clk),
    .clear        (clear),
    .start        (start),
    .stop         (stop),
    .target       (target),
    .cnt_in       (cnt_in),
    .cnt_clear    (cnt_clear),
    .cnt_en       (cnt_en),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .mismatch     (mismatch),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: clears while cnt_clear, counts on cnt_en, outputs delayed two cycles.
  logic [N-1:0] cnt_int = '0;
  logic [N-1:0] d1 = '0;
  logic [N-1:0] d2 = '0;
  logic [N-1:0] tog = 4'h5;
  logic         dropped = 1'b0;
  bit           drop_one = 0;
  bit           toggle_mode = 0;

  always @(posedge clk) begin
    if (cnt_clear) begin
      cnt_int <= '0;
      dropped <= 1'b0;
    end else if (cnt_en) begin
      if (drop_one && !dropped) dropped <= 1'b1;
      else                      cnt_int <= cnt_int + 4'd1;
    end
    d1  <= cnt_int;
    d2  <= d1;
    tog <= ~tog;
  end

  assign cnt_in = toggle_mode ? tog : d2;

  task automatic run_meas(input logic [N-1:0] tgt, input int stop_at, input bit poke_start,
                          output int lat, output int n_en, output int n_clr, output bit tmo);
    target = tgt;
    start  = 1'b1;
    lat = 0; n_en = 0; n_clr = 0; tmo = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
      lat++;
      if (cnt_en) n_en++;
      if (cnt_clear) n_clr++;
      if (stop_at > 0 && cnt_en && n_en == stop_at) stop = 1'b1;
      if (poke_start && cnt_en && n_en == 1) start = 1'b1;
      if (result_valid) begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic accept();
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({cnt_clear, cnt_en, result, result_valid, mismatch, busy} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required 0", {cnt_clear, cnt_en, result, result_valid, mismatch, busy});
    end
    clear = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat, n_en, n_clr; bit tmo; exp_t e;
    sb.push_back('{res: 4'd5, mm: 1'b0, chk_res: 1'b1});
    run_meas(4'd5, 0, 0, lat, n_en, n_clr, tmo);
    e = sb.pop_front();
    n_tests++; if (tmo) begin n_fail++; $display("FAIL basic_timeout: no result_valid"); end
    n_tests++; if (n_clr !== CLR_CYC) begin n_fail++; $display("FAIL basic_clr_cycles: got %0d required %0d", n_clr, CLR_CYC); end
    n_tests++; if (n_en !== 5) begin n_fail++; $display("FAIL basic_en_cycles: got %0d required 5", n_en); end
    n_tests++; if (lat !== 1 + CLR_CYC + 5 + SET_CYC + 3) begin n_fail++; $display("FAIL basic_latency: got %0d required %0d", lat, 1 + CLR_CYC + 5 + SET_CYC + 3); end
    n_tests++; if (result !== e.res) begin n_fail++; $display("FAIL basic_result: got %0d required %0d", result, e.res); end
    n_tests++; if (mismatch !== e.mm) begin n_fail++; $display("FAIL basic_mismatch: got %b required %b", mismatch, e.mm); end
    accept();
  endtask

  task automatic test_zero();
    int lat, n_en, n_clr; bit tmo; exp_t e;
    sb.push_back('{res: 4'd0, mm: 1'b0, chk_res: 1'b1});
    run_meas(4'd0, 0, 0, lat, n_en, n_clr, tmo);
    e = sb.pop_front();
    n_tests++; if (tmo || n_en !== 0) begin n_fail++; $display("FAIL zero_en_cycles: got %0d timeout %b required 0", n_en, tmo); end
    n_tests++; if (lat !== 1 + CLR_CYC + SET_CYC + 3) begin n_fail++; $display("FAIL zero_latency: got %0d required %0d", lat, 1 + CLR_CYC + SET_CYC + 3); end
    n_tests++; if ({result, mismatch} !== {e.res, e.mm}) begin n_fail++; $display("FAIL zero_result: got %0d/%b required %0d/%b", result, mismatch, e.res, e.mm); end
    accept();
  endtask

  task automatic test_stop();
    int lat, n_en, n_clr; bit tmo; exp_t e;
    sb.push_back('{res: 4'd3, mm: 1'b0, chk_res: 1'b1});
    run_meas(4'd9, 3, 1, lat, n_en, n_clr, tmo);
    e = sb.pop_front();
    n_tests++; if (tmo || n_en !== 3) begin n_fail++; $display("FAIL stop_en_cycles: got %0d timeout %b required 3", n_en, tmo); end
    n_tests++; if ({result, mismatch} !== {e.res, e.mm}) begin n_fail++; $display("FAIL stop_result: got %0d/%b required %0d/%b", result, mismatch, e.res, e.mm); end
    accept();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle_after: busy %b required 0", busy); end
    repeat (4) @(posedge clk);
    #1;
    n_tests++; if ({busy, cnt_clear} !== 2'b00) begin n_fail++; $display("FAIL busy_start_ignored: busy/clr %b required 00", {busy, cnt_clear}); end
  endtask

  task automatic test_hold();
    int lat, n_en, n_clr; bit tmo; exp_t e; int bad;
    sb.push_back('{res: 4'd15, mm: 1'b0, chk_res: 1'b1});
    run_meas(4'd15, 0, 0, lat, n_en, n_clr, tmo);
    e = sb.pop_front();
    n_tests++; if (tmo || lat !== 1 + CLR_CYC + 15 + SET_CYC + 3) begin n_fail++; $display("FAIL hold_latency: got %0d timeout %b required %0d", lat, tmo, 1 + CLR_CYC + 15 + SET_CYC + 3); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if ({result_valid, result, mismatch} !== {1'b1, e.res, e.mm}) bad++;
      @(posedge clk); #1;
    end
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL hold_stable: %0d unstable cycles, required 0 (result %0d valid %b)", bad, result, result_valid); end
    accept();
    n_tests++; if ({result_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL hold_release: valid/busy %b required 00", {result_valid, busy}); end
    n_tests++; if (result !== e.res) begin n_fail++; $display("FAIL hold_result_kept: got %0d required %0d", result, e.res); end
  endtask

  task automatic test_mismatch();
    int lat, n_en, n_clr; bit tmo; exp_t e;
    drop_one = 1;
    sb.push_back('{res: 4'd5, mm: 1'b1, chk_res: 1'b1});
    run_meas(4'd6, 0, 0, lat, n_en, n_clr, tmo);
    e = sb.pop_front();
    drop_one = 0;
    n_tests++; if (tmo || {result, mismatch} !== {e.res, e.mm}) begin n_fail++; $display("FAIL drop_result: got %0d/%b required %0d/%b", result, mismatch, e.res, e.mm); end
    accept();
    n_tests++; if (mismatch !== 1'b1) begin n_fail++; $display("FAIL drop_mismatch_kept: got %b required 1", mismatch); end
    toggle_mode = 1;
    sb.push_back('{res: 4'd0, mm: 1'b1, chk_res: 1'b0});
    run_meas(4'd2, 0, 0, lat, n_en, n_clr, tmo);
    e = sb.pop_front();
    toggle_mode = 0;
    n_tests++; if (tmo || mismatch !== e.mm) begin n_fail++; $display("FAIL toggle_mismatch: got %b timeout %b required %b", mismatch, tmo, e.mm); end
    n_tests++; if (lat !== 1 + CLR_CYC + 2 + SET_CYC + 3 + (4 - 1)) begin n_fail++; $display("FAIL toggle_latency: got %0d required %0d", lat, 1 + CLR_CYC + 2 + SET_CYC + 3 + 3); end
    accept();
  endtask

  task automatic test_abort();
    int lat, n_en, n_clr; bit tmo; exp_t e; int seen;
    target = 4'd9;
    start  = 1'b1;
    seen   = 0;
    for (int i = 0; i < 50 && seen < 2; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cnt_en) seen++;
    end
    n_tests++; if (seen !== 2) begin n_fail++; $display("FAIL abort_reach_run: pulses %0d required 2", seen); end
    #2 clear = 1'b1;
    #1;
    n_tests++; if ({cnt_en, busy, result_valid} !== 3'b000) begin n_fail++; $display("FAIL abort_async: en/busy/valid %b required 000", {cnt_en, busy, result_valid}); end
    @(posedge clk); #1;
    clear = 1'b0;
    @(posedge clk); #1;
    sb.push_back('{res: 4'd2, mm: 1'b0, chk_res: 1'b1});
    run_meas(4'd2, 0, 0, lat, n_en, n_clr, tmo);
    e = sb.pop_front();
    n_tests++; if (tmo || {result, mismatch} !== {e.res, e.mm}) begin n_fail++; $display("FAIL abort_rerun: got %0d/%b timeout %b required %0d/%b", result, mismatch, tmo, e.res, e.mm); end
    accept();
  endtask

  initial begin
    clear        = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    target       = '0;
    result_ready = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_stop();
    test_hold();
    test_mismatch();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
